// File: rtl/nibbler_ctrl_pkg.sv
// Shared constants and types for the Nibbler slice sequencer.
package nibbler_ctrl_pkg;

  localparam int N_SLICES_DEF = 8;
  localparam int IDX_BITS_DEF = 3;

  localparam logic DIR_ASC  = 1'b1;
  localparam logic DIR_DESC = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/slice_seq_counter.sv
// Slice counter plus demux-index mirror. Produces the first/last flags for the current slice.
module slice_seq_counter
  import nibbler_ctrl_pkg::*;
#(
  parameter int N_SLICES = N_SLICES_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_max_i,
  input  logic                step_i,
  input  logic                dir_i,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                first_o,
  output logic                last_o
);

  localparam int CNT_W = IDX_BITS + 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CNT_W'(N_SLICES - 1));
  assign idx_o   = idx_q;

  // The last slice always lands the mirror on 0 so idle implies index 0 in either direction.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load_max_i) begin
      idx_d = IDX_BITS'(N_SLICES - 1);
    end else if (step_i) begin
      if (last_o) begin
        cnt_d = '0;
        idx_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = (dir_i == DIR_ASC) ? idx_q + 1'b1 : idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/slice_sequencer_ctrl.sv
// Sequences one slice pass per request, steering the external shift-demux so it rests at 0 when idle.
module slice_sequencer_ctrl
  import nibbler_ctrl_pkg::*;
#(
  parameter int N_SLICES = N_SLICES_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic                req_dir,
  input  logic                stall,
  output logic                dmx_en,
  output logic                dmx_dir,
  output logic                slice_val,
  output logic [IDX_BITS-1:0] slice_idx,
  output logic                slice_first,
  output logic                slice_last,
  output logic                done,
  output logic                busy
);

  seq_state_e          state_q;
  logic                dir_q;
  logic                rdy_q, busy_q;
  logic                run, consume;
  logic                first, last;
  logic [IDX_BITS-1:0] idx;

  assign run     = (state_q == RUN);
  assign consume = run && !stall && !reset;

  slice_seq_counter #(
    .N_SLICES (N_SLICES),
    .IDX_BITS (IDX_BITS)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_max_i (state_q == PREP),
    .step_i     (consume),
    .dir_i      (dir_q),
    .idx_o      (idx),
    .first_o    (first),
    .last_o     (last)
  );

  // PREP walks the demux 0 -> N-1 so a descending pass starts at the top slice.
  assign dmx_en      = (state_q == PREP) || (consume && (dir_q == DIR_ASC || !last));
  assign dmx_dir     = run && dir_q;
  assign slice_val   = run;
  assign slice_idx   = idx;
  assign slice_first = run && first;
  assign slice_last  = run && last;
  assign done        = consume && last;
  assign req_rdy     = rdy_q;
  assign busy        = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_ASC;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_val) begin
          dir_q   <= req_dir;
          state_q <= (req_dir == DIR_ASC) ? RUN : PREP;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
        PREP: state_q <= RUN;
        RUN: if (done) begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  a_idle_idx0: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> (idx == '0));
  a_idle_no_en: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> !dmx_en);

endmodule

// File: tb/tb_slice_sequencer_ctrl.sv
// Randomized + directed bench for slice_sequencer_ctrl with a pass-level reference model and demux model.
module tb_slice_sequencer_ctrl;

  localparam int N  = 8;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          reset, req_val, req_dir, stall;
  logic          req_rdy, dmx_en, dmx_dir, slice_val, slice_first, slice_last, done, busy;
  logic [IB-1:0] slice_idx;

  int n_chk = 0;
  int n_err = 0;

  // Reference: mode 0 idle, 1 prep, 2 run; k = slices consumed in this pass; d = latched direction.
  int m = 0;
  int k = 0;
  int d = 1;
  int dmx = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  slice_sequencer_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_dir     (req_dir),
    .stall       (stall),
    .dmx_en      (dmx_en),
    .dmx_dir     (dmx_dir),
    .slice_val   (slice_val),
    .slice_idx   (slice_idx),
    .slice_first (slice_first),
    .slice_last  (slice_last),
    .done        (done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge against the model, then advance the model.
  task automatic cycle(input logic rv, input logic rd, input logic st, input logic rs);
    logic cons, e_en, s_en, s_dir;
    int   e_idx;
    req_val = rv; req_dir = rd; stall = st; reset = rs;
    @(negedge clk);
    cons  = (m == 2) && !st && !rs;
    e_idx = (m == 2) ? (d ? k : N - 1 - k) : 0;
    e_en  = (m == 1) || (cons && (d == 1 || k != N - 1));
    chk("req_rdy",   32'(req_rdy),     32'(m == 0));
    chk("busy",      32'(busy),        32'(m != 0));
    chk("slice_val", 32'(slice_val),   32'(m == 2));
    chk("slice_idx", 32'(slice_idx),   32'(e_idx));
    chk("first",     32'(slice_first), 32'(m == 2 && k == 0));
    chk("last",      32'(slice_last),  32'(m == 2 && k == N - 1));
    chk("done",      32'(done),        32'(cons && k == N - 1));
    chk("dmx_en",    32'(dmx_en),      32'(e_en));
    chk("dmx_dir",   32'(dmx_dir),     32'(m == 2 && d == 1));
    if (m == 2) chk("dmx_vs_idx", 32'(dmx), 32'(slice_idx));
    if (m == 0) chk("dmx_idle0",  32'(dmx), 32'(0));
    if (done) n_done++;
    s_en = dmx_en; s_dir = dmx_dir;
    @(posedge clk);
    if (rs) begin
      m = 0; k = 0; d = 1; dmx = 0;
    end else begin
      if (s_en) dmx = (s_dir ? dmx + 1 : dmx - 1) & (N - 1);
      case (m)
        0: if (rv) begin d = rd ? 1 : 0; m = rd ? 2 : 1; k = 0; end
        1: m = 2;
        default: if (cons) begin
          if (k == N - 1) begin m = 0; k = 0; end
          else k++;
        end
      endcase
    end
    #1;
  endtask

  initial begin
    int nd0;
    reset = 1'b1; req_val = 1'b0; req_dir = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    cycle(0, 0, 0, 1);
    cycle(1, 1, 0, 1);

    // Ascending, no stall
    nd0 = n_done;
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    chk("asc_done_cnt", 32'(n_done - nd0), 32'(1));

    // Descending, no stall
    nd0 = n_done;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, 0);
    chk("desc_done_cnt", 32'(n_done - nd0), 32'(1));

    // Ascending with a 3-cycle stall on idx 4
    nd0 = n_done;
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("stall_done_cnt", 32'(n_done - nd0), 32'(1));

    // req_val held high with mixed directions
    for (int i = 0; i < 40; i++) cycle(1, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // Reset during descending RUN at idx 3, then an ascending pass
    nd0 = n_done;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("pre_rst_idx", 32'(slice_idx), 32'(3));
    cycle(0, 0, 0, 1);
    chk("rst_no_done", 32'(n_done - nd0), 32'(0));
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // Back-to-back descending then ascending
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // Random traffic including stalls and occasional resets
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/slice_sequencer_ctrl.md
Name: slice_sequencer_ctrl

Overview:
- Sequences multi-cycle subword (slice) operations in the Nibbler bit-serial datapath.
- Accepts one operation request at a time via a valid/ready handshake.
- Steps the 3-bit shift-demux index register through all slices, ascending (LSB->MSB) or descending (MSB->LSB), by driving its `en`/`direction` inputs.
- Emits per-slice strobes (first/last/valid) to the datapath, and guarantees the demux index is 0 whenever the block is idle.

Parameters:
- N_SLICES, 8, slices per operation; must equal 2^IDX_BITS.
- IDX_BITS, 3, width of the slice index; must match the demux index width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_val  input  1  operation request valid
- req_rdy  output  1  block can accept a request
- req_dir  input  1  1 = ascending pass (0..N-1), 0 = descending pass (N-1..0)
- stall  input  1  downstream stall; holds the current slice
- dmx_en  output  1  drives the shift-demux `en` input
- dmx_dir  output  1  drives the shift-demux `direction` input
- slice_val  output  1  a slice is being presented this cycle
- slice_idx  output  IDX_BITS  mirror of the demux index for the current slice
- slice_first  output  1  current slice is the first of the pass
- slice_last  output  1  current slice is the last of the pass
- done  output  1  one-cycle pulse when the last slice is consumed
- busy  output  1  state != IDLE

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values: state=IDLE, idx mirror=0, cnt=0, dir reg=1. All outputs 0 except req_rdy=1. The demux shares the same reset, so both indices are 0 after reset.
- FSM states:
  - IDLE: req_rdy=1. On req_val, latch req_dir.
    - If req_dir=1, go to RUN with mirror=0.
    - If req_dir=0, go to PREP.
  - PREP: dmx_en=1, dmx_dir=0 (demux index 0->N-1); mirror<=N-1. Always goes to RUN next cycle. Ignores stall.
  - RUN: slice_val=1; slice_idx=mirror; slice_first=(cnt==0); slice_last=(cnt==N_SLICES-1).
    - A slice is consumed when stall=0. On consume: cnt++ and the mirror moves in the latched direction.
    - dmx_dir = latched direction.
    - dmx_en = consume AND (ascending OR NOT slice_last). Ascending wraps N-1->0 on the last slice; descending stays at 0 on the last slice. Either way the demux ends at 0.
    - On consuming the last slice: done=1 in that same cycle, cnt<=0, and the next state is IDLE.
  - Stall in RUN: dmx_en=0; idx, cnt and slice outputs hold; slice_val stays 1.
- Latency (req accept to first slice_val):
  - Ascending: 1 cycle.
  - Descending: 2 cycles.
- Pass length with no stalls:
  - Ascending: N cycles.
  - Descending: N+1 cycles.
- req_rdy=0 outside IDLE. A request is not accepted in the done cycle; the earliest next accept is the following cycle, in IDLE.
- Arithmetic: mirror is modulo 2^IDX_BITS. cnt is IDX_BITS+1 bits wide, or compared before wrap.
- Reset mid-operation (any state, including while stalled): return to IDLE in the next cycle with mirror 0 and no done pulse. The demux is reset in the same cycle, so the two stay consistent.
- Invariant (assertion): when state==IDLE, mirror==0.
- Invariant (assertion): dmx_en is never asserted in IDLE.

Decomposition:
- Shared package (nibbler_ctrl_pkg):
  - state encoding constants: IDLE=2'd0, PREP=2'd1, RUN=2'd2;
  - DIR_ASC=1'b1, DIR_DESC=1'b0;
  - N_SLICES and IDX_BITS defaults.
- One natural sub-module, slice_seq_counter: holds cnt plus the idx mirror and produces first/last. The FSM stays in the parent.
- The shift-demux is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset, then an ascending req with stall=0 -> slice_val for 8 cycles with idx 0,1,...,7; first on idx 0; last and done on idx 7; dmx_en=1 all 8 cycles; demux idx=0 afterwards; req_rdy=1 in the next cycle.
- Descending req, no stall -> PREP cycle with dmx_en=1 and dmx_dir=0; then idx 7,6,...,0; dmx_en high on the first 7 RUN cycles only; done on idx 0; demux idx=0.
- Ascending req with stall held high for 3 cycles at idx 4 -> idx 4 held with slice_val=1 and dmx_en=0; then idx 5..7 resume; total 11 RUN cycles; exactly one done.
- req_val held high continuously -> accepts separated by exactly one IDLE cycle after done; no req_rdy during RUN or PREP.
- Reset asserted during descending RUN at idx 3 -> next cycle IDLE, mirror 0, demux 0, no done pulse; a subsequent ascending pass starts at idx 0.
- Back-to-back descending then ascending requests -> demux index equals slice_idx on every slice_val cycle, checked by a scoreboard against the demux model.
